// File: rtl/nios_timer_pkg.sv
// Shared register map and bit indices for the Nios II interval timer.
package nios_timer_pkg;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t ADDR_STATUS  = 3'd0;
    localparam reg_addr_t ADDR_CONTROL = 3'd1;
    localparam reg_addr_t ADDR_PERIODL = 3'd2;
    localparam reg_addr_t ADDR_PERIODH = 3'd3;
    localparam reg_addr_t ADDR_SNAPL   = 3'd4;
    localparam reg_addr_t ADDR_SNAPH   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam int unsigned STAT_TO  = 0;
    localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/nios_interval_timer_if.sv
// Avalon-MM 16-bit slave bus plus IRQ line for the interval timer.
interface nios_interval_timer_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/nios_timer_core.sv
// Down-counter with zero-detect reload, RUN flag and a one-cycle timeout pulse.
module nios_timer_core #(
    parameter int unsigned        COUNT_W     = 32,
    parameter logic [COUNT_W-1:0] RESET_COUNT = '0,
    parameter bit                 RESET_RUN   = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_cont,
    input  logic [COUNT_W-1:0] i_period,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_run,
    output logic               o_timeout
);

    logic [COUNT_W-1:0] r_count;
    logic               r_run;
    logic               w_timeout;

    assign w_timeout = r_run && (r_count == '0);

    // i_period already carries any same-cycle period write, so one source serves load and reload.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= RESET_COUNT;
            r_run   <= RESET_RUN;
        end else begin
            if (i_load || w_timeout) begin
                r_count <= i_period;
            end else if (r_run) begin
                r_count <= r_count - COUNT_W'(1);
            end

            if (i_load || i_stop) begin
                r_run <= 1'b0;
            end else if (i_start) begin
                r_run <= 1'b1;
            end else if (w_timeout && !i_cont) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_count   = r_count;
    assign o_run     = r_run;
    assign o_timeout = w_timeout;

endmodule

// File: rtl/nios_interval_timer.sv
// Avalon-MM interval timer: register decode, period/snapshot/control state, TO flag, read mux.
module nios_interval_timer
    import nios_timer_pkg::*;
#(
    parameter int unsigned COUNT_W      = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h0007_A11F,
    parameter bit          RESET_CONT   = 1'b1,
    parameter bit          RESET_RUN    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios_interval_timer_if.slave   if_avs
);

    localparam logic [COUNT_W-1:0] RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];

    logic               w_wr, w_wr_status, w_wr_ctrl, w_wr_perl, w_wr_perh, w_wr_snap;
    logic [COUNT_W-1:0] r_period, w_period_d, r_snap, w_count;
    logic               r_to, r_ito, r_cont;
    logic               w_run, w_timeout;
    logic [15:0]        r_readdata, w_rdata;
    logic [31:0]        w_period_ext, w_snap_ext;

    assign w_wr        = if_avs.chipselect && !if_avs.write_n;
    assign w_wr_status = w_wr && (if_avs.address == ADDR_STATUS);
    assign w_wr_ctrl   = w_wr && (if_avs.address == ADDR_CONTROL);
    assign w_wr_perl   = w_wr && (if_avs.address == ADDR_PERIODL);
    assign w_wr_perh   = w_wr && (if_avs.address == ADDR_PERIODH);
    assign w_wr_snap   = w_wr && ((if_avs.address == ADDR_SNAPL) ||
                                  (if_avs.address == ADDR_SNAPH));

    always_comb begin
        w_period_d = r_period;
        if (w_wr_perl) w_period_d[15:0] = if_avs.writedata;
        if (w_wr_perh) w_period_d[COUNT_W-1:16] = if_avs.writedata[COUNT_W-17:0];
    end

    nios_timer_core #(
        .COUNT_W     (COUNT_W),
        .RESET_COUNT (RST_PERIOD),
        .RESET_RUN   (RESET_RUN)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_wr_perl || w_wr_perh),
        .i_start   (w_wr_ctrl && if_avs.writedata[CTRL_START]),
        .i_stop    (w_wr_ctrl && if_avs.writedata[CTRL_STOP]),
        .i_cont    (r_cont),
        .i_period  (w_period_d),
        .o_count   (w_count),
        .o_run     (w_run),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_period   <= RST_PERIOD;
            r_snap     <= '0;
            r_to       <= 1'b0;
            r_ito      <= 1'b0;
            r_cont     <= RESET_CONT;
            r_readdata <= '0;
        end else begin
            r_period   <= w_period_d;
            r_readdata <= w_rdata;
            if (w_wr_snap) r_snap <= w_count;
            // A timeout in the same cycle as a STATUS write must leave TO set.
            if (w_timeout) begin
                r_to <= 1'b1;
            end else if (w_wr_status) begin
                r_to <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_ito  <= if_avs.writedata[CTRL_ITO];
                r_cont <= if_avs.writedata[CTRL_CONT];
            end
        end
    end

    assign w_period_ext = 32'(r_period);
    assign w_snap_ext   = 32'(r_snap);

    always_comb begin
        w_rdata = '0;
        case (if_avs.address)
            ADDR_STATUS: begin
                w_rdata[STAT_TO]  = r_to;
                w_rdata[STAT_RUN] = w_run;
            end
            ADDR_CONTROL: begin
                w_rdata[CTRL_ITO]  = r_ito;
                w_rdata[CTRL_CONT] = r_cont;
            end
            ADDR_PERIODL: w_rdata = w_period_ext[15:0];
            ADDR_PERIODH: w_rdata = w_period_ext[31:16];
            ADDR_SNAPL:   w_rdata = w_snap_ext[15:0];
            ADDR_SNAPH:   w_rdata = w_snap_ext[31:16];
            default:      w_rdata = '0;
        endcase
    end

    assign if_avs.readdata = r_readdata;
    assign if_avs.irq      = r_to && r_ito;

endmodule

// File: doc/nios_interval_timer.md
# nios_interval_timer

Parametrised Avalon-MM interval timer for the Nios II system: the successor to the fixed-period timer, with a programmable period, configurable counter width, start/stop control, one-shot or continuous mode and a counter snapshot. It sits on the processor data bus as a 16-bit slave and drives one level-sensitive IRQ line to the interrupt controller.

## Interface
Parameters:
- `COUNT_W`, 32: counter and period width, legal range 17..32.
- `RESET_PERIOD`, 32'h0007_A11F: period and counter value after reset, truncated to `COUNT_W`.
- `RESET_CONT`, 1: CONT bit value after reset.
- `RESET_RUN`, 0: 1 means the counter runs out of reset.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `address` in 3: register word select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data. Resets to 0.
- `irq` out 1: `TO && ITO`. Resets to 0.

## Operation
Register map (16-bit words):
- **0 STATUS**
  - Bit 0: TO.
  - Bit 1: RUN.
  - Any write clears TO.
- **1 CONTROL**
  - Bit 0: ITO.
  - Bit 1: CONT.
  - Bit 2: START, write-only strobe.
  - Bit 3: STOP, write-only strobe.
  - Reads return {STOP=0, START=0, CONT, ITO}.
- **2 PERIODL / 3 PERIODH**
  - Low and high halves of the period.
  - PERIODH bits at or above `COUNT_W-16` are ignored on write and read 0.
- **4 SNAPL / 5 SNAPH**
  - Any write to either word copies the live counter into the snapshot register.
  - Reads return the snapshot, not the live counter.
- **6, 7**: read 0, writes ignored.

Counter behaviour:
- When RUN is set, the counter decrements by 1 each cycle.
- When RUN is set and the counter is 0:
  - The next cycle reloads the counter from the period, instead of decrementing.
  - TO is set on that same cycle.
  - If CONT is 0, RUN is cleared on that same cycle (one-shot).
- A period of P gives a timeout every P+1 cycles. P=0 gives a timeout every cycle while running.
- Writing PERIODL or PERIODH does three things on the next edge:
  - updates that half of the period;
  - clears RUN;
  - loads the counter with the new period.
- START sets RUN. STOP clears RUN. The counter holds its value while RUN is 0.

Simultaneous events, same cycle:
- START and STOP together: STOP wins.
- STATUS write and timeout: TO ends set.
- Period write and timeout: the counter loads the new period, RUN ends 0, TO is set.
- START and zero-reload: RUN ends set, the counter reloads.
- Snapshot write and decrement: the snapshot captures the pre-decrement value.

Reset values:
- Counter and period: `RESET_PERIOD`.
- TO, ITO and snapshot: 0.
- CONT: `RESET_CONT`.
- RUN: `RESET_RUN`.
- `readdata` and `irq`: 0.
- Asserting `reset_n` mid-count restores all reset values on the next edge.

## Timing
- **Writes:** a write in cycle t takes effect at the edge that ends cycle t.
- **Reads:** `readdata` is registered every cycle from the address mux, so data is valid in cycle t+1. There are no wait states. `readdata` updates regardless of `chipselect`.
- **IRQ:** `irq` is combinational from registered TO and ITO.
  - It rises in the cycle after the counter reads 0.
  - It falls in the cycle after a STATUS write or a write that clears ITO.
- **Snapshot:** a snapshot write in cycle t makes the new value readable by a read issued in cycle t+1, which returns data in cycle t+2.

## Structure
Shared package `nios_timer_pkg`:
- register address constants `ADDR_STATUS` .. `ADDR_SNAPH`;
- control bit indices `CTRL_ITO`, `CTRL_CONT`, `CTRL_START`, `CTRL_STOP`;
- status bit indices `STAT_TO`, `STAT_RUN`.

Sub-module `nios_timer_core` contains:
- the `COUNT_W` down-counter;
- the zero detect and reload;
- the RUN flag;
- the timeout pulse.

Its inputs are load, start and stop strobes plus the period. The top level keeps:
- Avalon decode;
- control, period and snapshot registers;
- the TO flag;
- the read mux.

## Test plan
1. **Reset defaults.** Release reset, then read STATUS, CONTROL, PERIODL and PERIODH. Required: 0x0, 0x2, 0xA11F, 0x0007. `irq`=0 throughout.
2. **Continuous mode.**
   - Stimulus: period=4, CONTROL=0x7 (ITO, CONT, START).
   - Required: `irq` rises 5 cycles after START takes effect.
   - Clear TO via STATUS; `irq` rises again 5 cycles later. RUN stays 1.
3. **One-shot mode.**
   - Stimulus: period=2, CONTROL=0x5 (ITO, START, CONT=0).
   - Required: TO set after 3 cycles, RUN reads 0, the counter holds at 2 (confirmed by snapshot), no further timeouts.
4. **Snapshot and stop.**
   - Stimulus: period=0x0001_0000, start, wait 10 cycles, write SNAPL.
   - Required: SNAPH:SNAPL = 0x0000_FFF6 ±1 per the documented capture cycle.
   - Then STOP: two snapshots taken 20 cycles apart are equal.
5. **Collisions.**
   - STOP and START in one write: RUN ends 0.
   - STATUS clear in the same cycle as a timeout: TO ends 1.
   - PERIODL write during a count: RUN ends 0 and the counter equals the new period.
6. **Width and mid-count reset.**
   - With `COUNT_W`=20, write PERIODH=0xFFFF; it reads back 0x000F.
   - Assert `reset_n` low for one cycle mid-count: all registers return to their reset values and `irq`=0 on the next cycle.
